multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter USE_MEM_READY, default 1, meaning: 1 = memory states wait on mem_ready; 0 = mem_ready ignored and every memory access completes in one cycle.
REQ-002 Parameter ALUC_W, default 4, meaning: width of alucontrol, using the existing ALU encoding (add 0010, sub 0110, or 0001, and 0000, slt 0111, sltu 1111).
REQ-003 clk  input  1  rising-edge system clock.
REQ-004 reset  input  1  active-low reset, asserted asynchronously (the codebase name is kept; polarity is low).
REQ-005 op, funct  input  6 each  fields of the instruction register.
REQ-006 zero, mem_ready  input  1 each  ALU zero flag; memory access done.
REQ-007 mem_req, memwrite, iord, irwrite, pcen, regwrite, alusrca, signext, shiftl16  output  1 each  datapath strobes and selects.
REQ-008 regdst, memtoreg, alusrcb, pcsrc  output  2 each  datapath mux selects.
REQ-009 alucontrol  output  ALUC_W  ALU operation.
REQ-010 illegal  output  1  one-cycle pulse on an undefined op or funct.
REQ-011 state  output  4  current FSM state, for debug.

Function
REQ-012 Mux encodings: regdst 0=rt, 1=rd, 2=r31; memtoreg 0=aluout, 1=readdata, 2=pc; alusrcb 0=reg, 1=const 4, 2=ext imm, 3=ext imm<<2; pcsrc 0=alu result, 1=aluout, 2=jump target, 3=srca.
REQ-013 Default in every state: all strobes 0, all selects 0, alucontrol=add.
REQ-014 FETCH: mem_req=1, iord=0, alusrcb=1; only on mem_ready: irwrite=1, pcen=1, go to DECODE; otherwise stay in FETCH with no writes.
REQ-015 DECODE: alusrcb=3, signext=1 (branch target into aluout); branch on op/funct to MEMADR (LW/SW), RTEX (R-type except JR), JREX (funct 001000), BREX (BEQ/BNE), IEX (ADDI/ADDIU/ORI/LUI/SLTI), JEX (J), JALEX (JAL).
REQ-016 MEMADR: alusrca=1, alusrcb=2, signext=1; go to MEMRD (LW) or MEMWR (SW).
REQ-017 MEMRD: mem_req=1, iord=1; stay until mem_ready, then go to MEMWB.
REQ-018 MEMWB: regwrite=1, regdst=0, memtoreg=1; go to FETCH.
REQ-019 MEMWR: mem_req=1, iord=1, memwrite=1; stay until mem_ready; memwrite stays high for the whole wait; then go to FETCH.
REQ-020 RTEX: alusrca=1, alucontrol from funct; go to RTWB. RTWB: regwrite=1, regdst=1; go to FETCH.
REQ-021 IEX: alusrca=1, alusrcb=2; signext=1 except ORI and LUI; shiftl16=1 for LUI; alucontrol add (ADDI/ADDIU/LUI), or (ORI), slt (SLTI); go to IWB. IWB: regwrite=1, regdst=0; go to FETCH.
REQ-022 BREX: alusrca=1, sub, pcsrc=1; pcen = zero for BEQ and ~zero for BNE; go to FETCH.
REQ-023 JEX: pcen=1, pcsrc=2; go to FETCH.
REQ-024 JALEX: pcen=1, pcsrc=2, regwrite=1, regdst=2, memtoreg=2 (pc already holds PC+4); go to FETCH.
REQ-025 JREX: alusrca=1, pcsrc=3, pcen=1; go to FETCH.
REQ-026 Undefined op or R-type funct in DECODE: illegal=1 for that cycle, no writes, go to FETCH.
REQ-027 mem_ready asserted outside FETCH/MEMRD/MEMWR is ignored; with USE_MEM_READY=0, mem_ready is treated as constant 1.
REQ-028 Outputs are a combinational (Moore-plus-op) decode of state, op, funct, zero and mem_ready; the state register is the only storage.

Reset
REQ-029 reset low forces state=FETCH asynchronously; while reset is low all outputs equal the REQ-013 defaults, except that FETCH's mem_req=1 is suppressed.
REQ-030 reset asserted mid-wait (MEMRD/MEMWR) abandons the access; memwrite drops in the same cycle.

Structure
REQ-031 A shared package holds the state encodings, the mux-select constants, the ALU-operation constants and the opcode/funct constants.
REQ-032 One sub-module, multicycle_aludec, maps (aluop, funct) to alucontrol and flags an illegal funct.

Verification
REQ-033 LW, op 100011, mem_ready low 3 cycles in MEMRD -> state sequence FETCH, DECODE, MEMADR, MEMRD x4, MEMWB; regwrite high only in MEMWB; 8 cycles total with a 1-cycle fetch.
REQ-034 BNE, op 000101, zero=0 -> pcen=1, pcsrc=1 in BREX; with zero=1 -> pcen=0.
REQ-035 JAL, op 000011 -> JALEX asserts regwrite, regdst=2, memtoreg=2, pcen, pcsrc=2, all in one cycle.
REQ-036 JR, funct 001000 -> JREX, pcsrc=3; funct 111111 -> illegal pulse, no regwrite.
REQ-037 SW with reset low during the MEMWR wait -> memwrite=0 immediately; state=FETCH; after release, fetch restarts.
REQ-038 USE_MEM_READY=0, mem_ready tied 0 -> R-type completes in 4 cycles (FETCH, DECODE, RTEX, RTWB).

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle controller: FSM states, datapath
// mux-select codes, ALU operation codes and instruction field values.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_IEX    = 4'd8,
        S_IWB    = 4'd9,
        S_BREX   = 4'd10,
        S_JEX    = 4'd11,
        S_JALEX  = 4'd12,
        S_JREX   = 4'd13
    } state_t;

    // Operation class handed to the ALU decoder
    typedef enum logic [2:0] {
        ALUOP_ADD   = 3'd0,
        ALUOP_SUB   = 3'd1,
        ALUOP_OR    = 3'd2,
        ALUOP_SLT   = 3'd3,
        ALUOP_FUNCT = 3'd4
    } aluop_t;

    localparam logic [1:0] REGDST_RT       = 2'd0;
    localparam logic [1:0] REGDST_RD       = 2'd1;
    localparam logic [1:0] REGDST_R31      = 2'd2;
    localparam logic [1:0] MEMTOREG_ALU    = 2'd0;
    localparam logic [1:0] MEMTOREG_MEM    = 2'd1;
    localparam logic [1:0] MEMTOREG_PC     = 2'd2;
    localparam logic [1:0] ALUSRCB_REG     = 2'd0;
    localparam logic [1:0] ALUSRCB_FOUR    = 2'd1;
    localparam logic [1:0] ALUSRCB_IMM     = 2'd2;
    localparam logic [1:0] ALUSRCB_IMM_SL2 = 2'd3;
    localparam logic [1:0] PCSRC_ALU       = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT    = 2'd1;
    localparam logic [1:0] PCSRC_JUMP      = 2'd2;
    localparam logic [1:0] PCSRC_SRCA      = 2'd3;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1111;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    // First execute state for an opcode. S_FETCH doubles as the
    // "undefined opcode" marker; R-type is refined later using funct.
    function automatic state_t op_target(input logic [5:0] op);
        case (op)
            OP_RTYPE:                                    return S_RTEX;
            OP_LW, OP_SW:                                return S_MEMADR;
            OP_BEQ, OP_BNE:                              return S_BREX;
            OP_ADDI, OP_ADDIU, OP_ORI, OP_LUI, OP_SLTI:  return S_IEX;
            OP_J:                                        return S_JEX;
            OP_JAL:                                      return S_JALEX;
            default:                                     return S_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_aludec.sv
// ALU decoder: turns the controller's operation class plus the R-type
// funct field into an ALU control word, and flags undefined functs.
module multicycle_aludec
    import multicycle_ctrl_pkg::*;
#(
    parameter int ALUC_W = 4
) (
    input  aluop_t              aluop,
    input  logic [5:0]          funct,
    output logic [ALUC_W-1:0]   alucontrol,
    output logic                funct_illegal
);

    logic [3:0] funct_alu;
    logic [3:0] alu_code;

    // R-type funct lookup; JR is legal but does not use the ALU result
    always_comb begin
        funct_alu     = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct)
            FN_ADD, FN_ADDU: funct_alu = ALU_ADD;
            FN_SUB, FN_SUBU: funct_alu = ALU_SUB;
            FN_AND:          funct_alu = ALU_AND;
            FN_OR:           funct_alu = ALU_OR;
            FN_SLT:          funct_alu = ALU_SLT;
            FN_SLTU:         funct_alu = ALU_SLTU;
            FN_JR:           funct_alu = ALU_ADD;
            default:         funct_illegal = 1'b1;
        endcase
    end

    // Select between fixed operations and the funct-derived one
    always_comb begin
        case (aluop)
            ALUOP_SUB:   alu_code = ALU_SUB;
            ALUOP_OR:    alu_code = ALU_OR;
            ALUOP_SLT:   alu_code = ALU_SLT;
            ALUOP_FUNCT: alu_code = funct_alu;
            default:     alu_code = ALU_ADD;
        endcase
    end

    assign alucontrol = ALUC_W'(alu_code);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style controller. The state register is the only storage;
// every output is decoded combinationally from state, op, funct, zero and
// mem_ready. reset is active-low and asynchronous.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int USE_MEM_READY = 1,
    parameter int ALUC_W        = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        op,
    input  logic [5:0]        funct,
    input  logic              zero,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              memwrite,
    output logic              iord,
    output logic              irwrite,
    output logic              pcen,
    output logic              regwrite,
    output logic              alusrca,
    output logic              signext,
    output logic              shiftl16,
    output logic [1:0]        regdst,
    output logic [1:0]        memtoreg,
    output logic [1:0]        alusrcb,
    output logic [1:0]        pcsrc,
    output logic [ALUC_W-1:0] alucontrol,
    output logic              illegal,
    output logic [3:0]        state
);

    state_t state_q;
    state_t state_d;
    state_t op_tgt;
    aluop_t aluop;
    logic   funct_illegal;
    logic   mem_rdy;
    logic   dec_illegal;

    // Without handshake support every memory access completes at once
    assign mem_rdy     = (USE_MEM_READY != 0) ? mem_ready : 1'b1;
    assign op_tgt      = op_target(op);
    assign dec_illegal = (op_tgt == S_FETCH) || ((op_tgt == S_RTEX) && funct_illegal);
    assign state       = state_q;

    multicycle_aludec #(.ALUC_W(ALUC_W)) u_aludec (
        .aluop         (aluop),
        .funct         (funct),
        .alucontrol    (alucontrol),
        .funct_illegal (funct_illegal)
    );

    // State register; asynchronous return to FETCH abandons any access
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    // Next-state selection
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (mem_rdy) state_d = S_DECODE;
            S_DECODE: begin
                state_d = op_tgt;
                if (op_tgt == S_RTEX) begin
                    if (funct == FN_JR)     state_d = S_JREX;
                    else if (funct_illegal) state_d = S_FETCH;
                end
            end
            S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_rdy) state_d = S_MEMWB;
            S_MEMWR:  if (mem_rdy) state_d = S_FETCH;
            S_RTEX:   state_d = S_RTWB;
            S_IEX:    state_d = S_IWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // Output decode; everything idles (no fetch request) while reset is low
    always_comb begin
        mem_req  = 1'b0;
        memwrite = 1'b0;
        iord     = 1'b0;
        irwrite  = 1'b0;
        pcen     = 1'b0;
        regwrite = 1'b0;
        alusrca  = 1'b0;
        signext  = 1'b0;
        shiftl16 = 1'b0;
        regdst   = REGDST_RT;
        memtoreg = MEMTOREG_ALU;
        alusrcb  = ALUSRCB_REG;
        pcsrc    = PCSRC_ALU;
        aluop    = ALUOP_ADD;
        illegal  = 1'b0;
        if (reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = ALUSRCB_FOUR;
                    irwrite = mem_rdy;
                    pcen    = mem_rdy;
                end
                S_DECODE: begin
                    alusrcb = ALUSRCB_IMM_SL2;
                    signext = 1'b1;
                    illegal = dec_illegal;
                end
                S_MEMADR: begin
                    alusrca = 1'b1;
                    alusrcb = ALUSRCB_IMM;
                    signext = 1'b1;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    regdst   = REGDST_RT;
                    memtoreg = MEMTOREG_MEM;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = 1'b1;
                end
                S_RTEX: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                S_RTWB: begin
                    regwrite = 1'b1;
                    regdst   = REGDST_RD;
                end
                S_IEX: begin
                    alusrca  = 1'b1;
                    alusrcb  = ALUSRCB_IMM;
                    signext  = !((op == OP_ORI) || (op == OP_LUI));
                    shiftl16 = (op == OP_LUI);
                    if (op == OP_ORI)       aluop = ALUOP_OR;
                    else if (op == OP_SLTI) aluop = ALUOP_SLT;
                end
                S_IWB: begin
                    regwrite = 1'b1;
                    regdst   = REGDST_RT;
                end
                S_BREX: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_SUB;
                    pcsrc   = PCSRC_ALUOUT;
                    pcen    = (op == OP_BNE) ? !zero : zero;
                end
                S_JEX: begin
                    pcen  = 1'b1;
                    pcsrc = PCSRC_JUMP;
                end
                S_JALEX: begin
                    pcen     = 1'b1;
                    pcsrc    = PCSRC_JUMP;
                    regwrite = 1'b1;
                    regdst   = REGDST_R31;
                    memtoreg = MEMTOREG_PC;
                end
                S_JREX: begin
                    alusrca = 1'b1;
                    pcsrc   = PCSRC_SRCA;
                    pcen    = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level plan model predicts the
// per-cycle control outputs, directed and random instructions are replayed.
`timescale 1ns/1ps
module tb_multicycle_ctrl;
    import multicycle_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT with memory handshake
    logic       reset, zero, mem_ready;
    logic [5:0] op, funct;
    logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, alusrca, signext, shiftl16, illegal;
    logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
    logic [3:0] alucontrol, state;

    // DUT that ignores mem_ready
    logic       reset0, zero0, mem_ready0;
    logic [5:0] op0, funct0;
    logic       mem_req0, memwrite0, iord0, irwrite0, pcen0, regwrite0, alusrca0, signext0, shiftl160, illegal0;
    logic [1:0] regdst0, memtoreg0, alusrcb0, pcsrc0;
    logic [3:0] alucontrol0, state0;

    multicycle_ctrl #(.USE_MEM_READY(1), .ALUC_W(4)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite), .pcen(pcen),
        .regwrite(regwrite), .alusrca(alusrca), .signext(signext), .shiftl16(shiftl16),
        .regdst(regdst), .memtoreg(memtoreg), .alusrcb(alusrcb), .pcsrc(pcsrc),
        .alucontrol(alucontrol), .illegal(illegal), .state(state)
    );

    multicycle_ctrl #(.USE_MEM_READY(0), .ALUC_W(4)) dut0 (
        .clk(clk), .reset(reset0), .op(op0), .funct(funct0), .zero(zero0), .mem_ready(mem_ready0),
        .mem_req(mem_req0), .memwrite(memwrite0), .iord(iord0), .irwrite(irwrite0), .pcen(pcen0),
        .regwrite(regwrite0), .alusrca(alusrca0), .signext(signext0), .shiftl16(shiftl160),
        .regdst(regdst0), .memtoreg(memtoreg0), .alusrcb(alusrcb0), .pcsrc(pcsrc0),
        .alucontrol(alucontrol0), .illegal(illegal0), .state(state0)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, alusrca, signext, shiftl16;
        logic [1:0] regdst, memtoreg, alusrcb, pcsrc;
        logic [3:0] aluc;
        logic       illegal;
    } cyc_t;

    cyc_t exp_q[$];
    cyc_t obs_q[$];
    logic rdy_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [5:0] op_tbl [0:11] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd13, 6'd15, 6'd35, 6'd43};
    logic [5:0] fn_tbl [0:9]  = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h2b, 6'h08, 6'h3f};

    function automatic cyc_t quiet(input logic [3:0] st);
        cyc_t c;
        c      = '0;
        c.st   = st;
        c.aluc = 4'b0010;
        return c;
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic cyc_t observe();
        cyc_t c;
        c.st = state; c.mem_req = mem_req; c.memwrite = memwrite; c.iord = iord;
        c.irwrite = irwrite; c.pcen = pcen; c.regwrite = regwrite; c.alusrca = alusrca;
        c.signext = signext; c.shiftl16 = shiftl16; c.regdst = regdst; c.memtoreg = memtoreg;
        c.alusrcb = alusrcb; c.pcsrc = pcsrc; c.aluc = alucontrol; c.illegal = illegal;
        return c;
    endfunction

    task automatic push(input cyc_t c, input logic r);
        exp_q.push_back(c);
        rdy_q.push_back(r);
    endtask

    // Instruction-level model: list the cycles one instruction should take,
    // with the mem_ready value to drive in each and the expected outputs.
    task automatic plan(input logic [5:0] o, input logic [5:0] f, input logic z, input int fw, input int mw);
        cyc_t c;
        logic [3:0] ralu;
        bit rok, ok_op;
        exp_q.delete();
        rdy_q.delete();
        for (int i = 0; i < fw; i++) begin
            c = quiet(S_FETCH); c.mem_req = 1; c.alusrcb = 2'd1;
            push(c, 1'b0);
        end
        c = quiet(S_FETCH); c.mem_req = 1; c.alusrcb = 2'd1; c.irwrite = 1; c.pcen = 1;
        push(c, 1'b1);
        rok = 1; ralu = 4'b0010;
        case (f)
            6'h20, 6'h21: ralu = 4'b0010;
            6'h22, 6'h23: ralu = 4'b0110;
            6'h24:        ralu = 4'b0000;
            6'h25:        ralu = 4'b0001;
            6'h2a:        ralu = 4'b0111;
            6'h2b:        ralu = 4'b1111;
            6'h08:        ralu = 4'b0010;
            default:      rok  = 0;
        endcase
        ok_op = (o inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd5, 6'd8, 6'd9, 6'd10, 6'd13, 6'd15, 6'd35, 6'd43});
        c = quiet(S_DECODE); c.alusrcb = 2'd3; c.signext = 1;
        c.illegal = !ok_op || (o == 6'd0 && !rok);
        push(c, rnd_bit());
        if (c.illegal) return;
        case (o)
            6'd35, 6'd43: begin
                c = quiet(S_MEMADR); c.alusrca = 1; c.alusrcb = 2'd2; c.signext = 1;
                push(c, rnd_bit());
                for (int i = 0; i <= mw; i++) begin
                    c = quiet((o == 6'd35) ? S_MEMRD : S_MEMWR);
                    c.mem_req = 1; c.iord = 1; c.memwrite = (o == 6'd43);
                    push(c, (i == mw));
                end
                if (o == 6'd35) begin
                    c = quiet(S_MEMWB); c.regwrite = 1; c.memtoreg = 2'd1;
                    push(c, rnd_bit());
                end
            end
            6'd0: begin
                if (f == 6'h08) begin
                    c = quiet(S_JREX); c.alusrca = 1; c.pcsrc = 2'd3; c.pcen = 1;
                    push(c, rnd_bit());
                end else begin
                    c = quiet(S_RTEX); c.alusrca = 1; c.aluc = ralu;
                    push(c, rnd_bit());
                    c = quiet(S_RTWB); c.regwrite = 1; c.regdst = 2'd1;
                    push(c, rnd_bit());
                end
            end
            6'd4, 6'd5: begin
                c = quiet(S_BREX); c.alusrca = 1; c.aluc = 4'b0110; c.pcsrc = 2'd1;
                c.pcen = (o == 6'd5) ? !z : z;
                push(c, rnd_bit());
            end
            6'd2: begin
                c = quiet(S_JEX); c.pcen = 1; c.pcsrc = 2'd2;
                push(c, rnd_bit());
            end
            6'd3: begin
                c = quiet(S_JALEX); c.pcen = 1; c.pcsrc = 2'd2; c.regwrite = 1;
                c.regdst = 2'd2; c.memtoreg = 2'd2;
                push(c, rnd_bit());
            end
            default: begin
                c = quiet(S_IEX); c.alusrca = 1; c.alusrcb = 2'd2;
                c.signext  = !(o == 6'd13 || o == 6'd15);
                c.shiftl16 = (o == 6'd15);
                c.aluc = (o == 6'd13) ? 4'b0001 : (o == 6'd10) ? 4'b0111 : 4'b0010;
                push(c, rnd_bit());
                c = quiet(S_IWB); c.regwrite = 1;
                push(c, rnd_bit());
            end
        endcase
    endtask

    // Replays the first n planned cycles and records the DUT outputs
    task automatic run_plan(input int n);
        obs_q.delete();
        for (int i = 0; i < n && i < exp_q.size(); i++) begin
            mem_ready = rdy_q[i];
            @(negedge clk);
            obs_q.push_back(observe());
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exec(input logic [5:0] o, input logic [5:0] f, input logic z, input int fw, input int mw);
        op = o; funct = f; zero = z;
        plan(o, f, z, fw, mw);
        run_plan(exp_q.size());
        $display("instr op=%b funct=%b zero=%b cycles=%0d", o, f, z, obs_q.size());
    endtask

    task automatic test_reset();
        cyc_t got;
        reset = 0; mem_ready = 1; op = 6'd35; funct = 0; zero = 0;
        @(posedge clk); #1;
        @(negedge clk);
        got = observe();
        n_checks++;
        if (got !== quiet(S_FETCH)) $display("FAIL reset_outputs: got %h want %h", got, quiet(S_FETCH));
        else n_pass++;
        @(posedge clk); #1;
        reset = 1; mem_ready = 0;
        @(negedge clk);
        n_checks++;
        if (state !== S_FETCH || mem_req !== 1'b1 || irwrite !== 1'b0)
            $display("FAIL reset_release: state=%0d mem_req=%b irwrite=%b want 0/1/0", state, mem_req, irwrite);
        else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_lw_wait();
        int wr;
        exec(6'd35, 6'h00, 1'b0, 0, 3);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL lw_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        wr = 0;
        foreach (obs_q[i]) if (obs_q[i].regwrite === 1'b1) wr++;
        n_checks++;
        if (wr != 1 || obs_q.size() != 8 || obs_q[7].st !== S_MEMWB)
            $display("FAIL lw_shape: regwrite_cycles=%0d cycles=%0d last_state=%0d want 1/8/%0d",
                     wr, obs_q.size(), obs_q[obs_q.size()-1].st, S_MEMWB);
        else n_pass++;
    endtask

    task automatic test_bne();
        for (int zz = 0; zz < 2; zz++) begin
            exec(6'd5, 6'h00, 1'(zz), $urandom_range(0, 2), 0);
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) $display("FAIL bne_z%0d_cycle%0d: got %h want %h", zz, i, obs_q[i], exp_q[i]);
                else n_pass++;
            end
            n_checks++;
            if (obs_q[obs_q.size()-1].pcen !== (zz == 0) || obs_q[obs_q.size()-1].pcsrc !== 2'd1)
                $display("FAIL bne_z%0d_pc: pcen=%b pcsrc=%0d want %b/1", zz,
                         obs_q[obs_q.size()-1].pcen, obs_q[obs_q.size()-1].pcsrc, zz == 0);
            else n_pass++;
        end
        exec(6'd4, 6'h00, 1'b1, 0, 0);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL beq_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_jal();
        cyc_t l;
        exec(6'd3, 6'h00, 1'b0, 1, 0);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL jal_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        l = obs_q[obs_q.size()-1];
        n_checks++;
        if (l.regwrite !== 1'b1 || l.regdst !== 2'd2 || l.memtoreg !== 2'd2 || l.pcen !== 1'b1 || l.pcsrc !== 2'd2)
            $display("FAIL jal_strobes: rw=%b rd=%0d m2r=%0d pcen=%b pcsrc=%0d want 1/2/2/1/2",
                     l.regwrite, l.regdst, l.memtoreg, l.pcen, l.pcsrc);
        else n_pass++;
    endtask

    task automatic test_jr_illegal();
        int wr;
        exec(6'd0, 6'h08, 1'b0, 0, 0);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL jr_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        exec(6'd0, 6'h3f, 1'b0, 0, 0);
        wr = 0;
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL badfunct_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
            if (obs_q[i].regwrite === 1'b1) wr++;
        end
        n_checks++;
        if (wr != 0 || obs_q[obs_q.size()-1].illegal !== 1'b1)
            $display("FAIL badfunct_pulse: regwrite_cycles=%0d illegal=%b want 0/1", wr, obs_q[obs_q.size()-1].illegal);
        else n_pass++;
        exec(6'h3f, 6'h20, 1'b0, 0, 0);
        foreach (exp_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL badop_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [5:0] o, f;
        int k;
        for (int n = 0; n < 80; n++) begin
            k = $urandom_range(0, 12);
            o = (k == 12) ? 6'($urandom) : op_tbl[k];
            k = $urandom_range(0, 10);
            f = (k == 10) ? 6'($urandom) : fn_tbl[k];
            exec(o, f, rnd_bit(), $urandom_range(0, 2), $urandom_range(0, 3));
            foreach (exp_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i])
                    $display("FAIL rand%0d_cycle%0d: op=%b funct=%b got %h want %h", n, i, o, f, obs_q[i], exp_q[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid_write();
        op = 6'd43; funct = 0; zero = 0;
        plan(6'd43, 6'h00, 1'b0, 0, 5);
        run_plan(5);
        $display("instr op=%b funct=%b zero=0 cycles=%0d (reset during wait)", op, funct, obs_q.size());
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) $display("FAIL swrst_cycle%0d: got %h want %h", i, obs_q[i], exp_q[i]);
            else n_pass++;
        end
        mem_ready = 0;
        #1;
        n_checks++;
        if (memwrite !== 1'b1 || state !== S_MEMWR) $display("FAIL swrst_waiting: memwrite=%b state=%0d want 1/%0d", memwrite, state, S_MEMWR);
        else n_pass++;
        reset = 0;
        #1;
        n_checks++;
        if (memwrite !== 1'b0 || mem_req !== 1'b0 || state !== S_FETCH)
            $display("FAIL swrst_abort: memwrite=%b mem_req=%b state=%0d want 0/0/%0d", memwrite, mem_req, state, S_FETCH);
        else n_pass++;
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        n_checks++;
        if (state !== S_FETCH || mem_req !== 1'b1 || irwrite !== 1'b0)
            $display("FAIL swrst_refetch: state=%0d mem_req=%b irwrite=%b want %0d/1/0", state, mem_req, irwrite, S_FETCH);
        else n_pass++;
        @(posedge clk); #1;
        mem_ready = 1;
        @(negedge clk);
        @(posedge clk); #1;
        n_checks++;
        if (state !== S_DECODE) $display("FAIL swrst_decode: state=%0d want %0d", state, S_DECODE);
        else n_pass++;
    endtask

    task automatic test_no_mem_ready();
        logic [3:0] want [0:4];
        want[0] = S_FETCH; want[1] = S_DECODE; want[2] = S_RTEX; want[3] = S_RTWB; want[4] = S_FETCH;
        op0 = 6'd0; funct0 = 6'h22; zero0 = 0; mem_ready0 = 0;
        reset0 = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (state0 !== want[i]) $display("FAIL nordy_state%0d: got %0d want %0d", i, state0, want[i]);
            else n_pass++;
            if (i == 0) begin
                n_checks++;
                if (irwrite0 !== 1'b1 || pcen0 !== 1'b1) $display("FAIL nordy_fetch: irwrite=%b pcen=%b want 1/1", irwrite0, pcen0);
                else n_pass++;
            end
            if (i == 2) begin
                n_checks++;
                if (alucontrol0 !== 4'b0110) $display("FAIL nordy_alu: got %b want 0110", alucontrol0);
                else n_pass++;
            end
            if (i == 3) begin
                n_checks++;
                if (regwrite0 !== 1'b1 || regdst0 !== 2'd1) $display("FAIL nordy_wb: regwrite=%b regdst=%0d want 1/1", regwrite0, regdst0);
                else n_pass++;
            end
            @(posedge clk); #1;
        end
        $display("instr op=%b funct=%b (mem_ready ignored) cycles=4", op0, funct0);
    endtask

    initial begin
        reset0 = 0; op0 = 0; funct0 = 0; zero0 = 0; mem_ready0 = 0;
        test_reset();
        test_lw_wait();
        test_bne();
        test_jal();
        test_jr_illegal();
        test_random();
        test_reset_mid_write();
        test_no_mem_ready();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
